// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default geometry
// and the running checksum helper.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int PROG_LEN_DEF = 16;
  localparam int AW_DEF       = 4;

  // Additive checksum: the carry out of bit 7 is deliberately dropped.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams PROG_LEN program bytes plus one checksum byte into RAM while holding
// the CPU, then releases it on a good checksum or flags an error on a bad one.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_we,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  // One extra count bit so the count can reach PROG_LEN itself without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(PROG_LEN - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t      state_r;
  logic [AW:0] count_r;
  logic [7:0]  sum_r;
  logic        xfer_s;

  assign xfer_s = in_valid & in_ready;

  // Loader FSM with all outputs registered; clr is a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r  <= IDLE;
      count_r  <= '0;
      sum_r    <= 8'h00;
      in_ready <= 1'b0;
      ram_addr <= '0;
      ram_data <= 8'h00;
      ram_we   <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_r  <= LOAD;
            count_r  <= '0;
            sum_r    <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            ram_addr <= count_r[AW-1:0];
            ram_data <= in_data;
            ram_we   <= 1'b1;
            sum_r    <= csum_add(sum_r, in_data);
            count_r  <= count_r + ONE;
            if (count_r == LAST_IDX) begin
              state_r <= CHECK;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        CHECK: begin
          // The checksum byte is compared, never written to RAM.
          if (xfer_s) begin
            in_ready <= 1'b0;
            if (in_data == sum_r) begin
              state_r  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r  <= ERR;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end else begin
            state_r <= CHECK;
          end
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads with a write
// scoreboard, plus hand-written stall, restart and reset-abort sequences.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0] first;
    logic [7:0] step;
    logic [7:0] csum;
    bit         gaps;
    bit         exp_done;
  } vec_t;
  vec_t vecs[5];

  prog_loader #(.PROG_LEN(16), .AW(4)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, ram_addr, ram_data}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", {28'd0, ram_addr}, {28'd0, w.addr});
        check("write_data", {24'd0, ram_data}, {24'd0, w.data});
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_done_clr", {30'd0, done, err}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_prog(input logic [7:0] first, input logic [7:0] step, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = first + 8'(i) * step;
      exp_q.push_back({4'(i), b});
      send(b);
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic check_end(input bit exp_done);
    check("end_done", {31'd0, done}, {31'd0, exp_done});
    check("end_err", {31'd0, err}, {31'd0, !exp_done});
    check("end_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    check("end_ready", {31'd0, in_ready}, 32'd0);
    check("end_queue_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {25'd0, in_ready, ram_we, cpu_hold, done, err, 2'b00}, 32'd0);
    check({name, "_bus"}, {20'd0, ram_addr, ram_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // first, step, checksum, gaps, expect good
    vecs[0] = '{8'h01, 8'h01, 8'h88, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 8'h01, 8'h87, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 8'h01, 8'h88, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 8'hF0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h10, 8'h80, 1'b1, 1'b1};

    clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    // Reset must win over start and in_valid on the same edge.
    start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    check_all_zero("reset_state");
    start = 1'b0; in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    check_all_zero("idle_state");

    for (int v = 0; v < 5; v++) begin
      do_start();
      send_prog(vecs[v].first, vecs[v].step, vecs[v].gaps);
      send(vecs[v].csum);
      check_end(vecs[v].exp_done);
    end

    // After completion, offered bytes must be ignored and done must persist.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_persist", {30'd0, done, err}, 32'd2);
    check("idle_not_ready", {31'd0, in_ready}, 32'd0);

    // A start pulse in the middle of a load is ignored.
    do_start();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({4'(i), 8'(i + 1)});
      send(8'(i + 1));
      if (i == 4) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midload_ready", {31'd0, in_ready}, 32'd1);
        check("midload_hold", {31'd0, cpu_hold}, 32'd1);
      end
    end
    send(8'h88);
    check_end(1'b1);

    // Reset after byte 7 aborts the load; a new start reloads from address 0.
    do_start();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({4'(i), 8'(8'h40 + i)});
      send(8'(8'h40 + i));
    end
    clr = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    check_all_zero("abort_state");
    clr = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("abort_idle");
    check("abort_queue_empty", exp_q.size(), 32'd0);
    do_start();
    send_prog(8'h01, 8'h01, 1'b0);
    send(8'h88);
    check_end(1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
